ro_freq_counter: RTL and testbench
==================================

Name: ro_freq_counter

Overview:
- Digital measurement stage directly downstream of the ring oscillator macro.
- Samples the digitized/divided oscillator signal in the system clock domain and counts its rising edges over a fixed gate window of clock cycles.
- Presents the result as a registered count with a one-cycle valid strobe, so the top level can route it to uo_out/uio_out for off-chip readout.

Parameters:
GATE_CYCLES, 1000, gate window length in clk cycles (>= 2)
CNT_W, 16, width of the edge counter and result (>= 8)
SYNC_STAGES, 2, synchronizer depth for ro_in (>= 2)

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
ro_in  input  1  oscillator signal, asynchronous to clk, already divided below fclk/2
start  input  1  level; starts one measurement when sampled high in IDLE
cont  input  1  level; continuous mode, re-arms automatically after each window
busy  output  1  high in ARM, COUNT and DONE
count_out  output  CNT_W  last completed window's edge count
count_valid  output  1  one-cycle pulse when count_out updates
overflow  output  1  last completed window saturated

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at a clk edge): FSM goes to IDLE. Synchronizer flops, edge flop, gate counter, edge counter, count_out, count_valid, overflow and busy all go to 0. Reset mid-window abandons the window; no valid pulse is generated.
- Synchronizer: ro_in passes through SYNC_STAGES flops, then one history flop.
  - Rising edge = sync_out high AND history low.
  - Edge detection latency is SYNC_STAGES+1 cycles.
  - Inputs at or above fclk/2 alias. This is a documented limit, not a checked condition.
- FSM states and transitions:
  - IDLE: busy=0. Goes to ARM when start=1 or cont=1.
  - ARM: exactly 1 cycle. Clears the gate counter, the edge counter and the window overflow flag. Goes to COUNT.
  - COUNT: lasts exactly GATE_CYCLES cycles.
    - Gate counter increments 0..GATE_CYCLES-1.
    - Each detected edge in a COUNT cycle increments the edge counter.
    - Edges detected in ARM, DONE or IDLE are ignored.
    - When the gate counter equals GATE_CYCLES-1, that cycle's edge is still counted, then the FSM goes to DONE.
  - DONE: 1 cycle.
    - count_out holds the final edge count and overflow holds the window flag; both are registered on entry to DONE.
    - count_valid=1 during the DONE cycle only.
    - Next state is ARM if cont=1, otherwise IDLE.
- Saturation: the edge counter holds at 2^CNT_W-1 and sets the window overflow flag; it never wraps.
- count_out and overflow hold their values until the next DONE or reset.
- start sampled while busy is ignored. start held high with cont=0 gives back-to-back single windows.
- Timing: start high at edge t in IDLE gives ARM at t+1, COUNT over t+2..t+1+GATE_CYCLES, and count_valid at t+2+GATE_CYCLES. In continuous mode the window period is GATE_CYCLES+2 cycles.
- Gate counter width is $clog2(GATE_CYCLES).

Optional Feature:
- Macro: RO_FREQ_BYTE_MUX_EN.
- When defined:
  - Adds input byte_sel [1:0] and output byte_out [7:0].
  - byte_out is a combinational select of count_out bytes: 0 = [7:0], 1 = [15:8] (zero above CNT_W), 2 = {7'b0, overflow}, 3 = 8'hA5 signature.
  - This supports pin-limited readout over uo_out.
- When undefined: those ports do not exist and behaviour is otherwise identical.

Test Plan:
- GATE_CYCLES=100, ro_in square wave with period 10 clk (5 high/5 low), start pulsed -> count_valid at start+102 with count_out=10, overflow=0.
- ro_in held 0, then held 1, start each time -> count_out=0 both times, overflow=0.
- CNT_W=8, GATE_CYCLES=600, ro_in period 2 clk (300 edges) -> count_out=255, overflow=1. Next window with period 10 -> count_out=60, overflow=0.
- cont=1 held, period-10 input, GATE_CYCLES=100 -> count_valid pulses exactly every 102 cycles, each with count_out=10. cont dropped -> FSM returns to IDLE after the current DONE.
- rst asserted mid-COUNT -> next cycle busy=0, count_out=0, no count_valid. start afterwards gives a correct full window.
- With RO_FREQ_BYTE_MUX_EN and count_out=16'h1234 -> byte_sel 0/1/2/3 gives 8'h34, 8'h12, 8'h00, 8'hA5.

Source files
------------

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized rising edges of ro_in over a gated window.
// Optional byte readout mux enabled by defining RO_FREQ_BYTE_MUX_EN.
module ro_freq_counter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_in,
    input  logic             start,
    input  logic             cont,
`ifdef RO_FREQ_BYTE_MUX_EN
    input  logic [1:0]       byte_sel,
    output logic [7:0]       byte_out,
`endif
    output logic             busy,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overflow
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   hist_p1;
    logic                   rise;
    logic [GW-1:0]          gate_cnt;
    logic [CNT_W-1:0]       edge_cnt;
    logic                   win_ovf;
    logic [CNT_W:0]         inc;
    logic [CNT_W-1:0]       edge_nxt;
    logic                   ovf_nxt;
    logic                   last_gate;

    // Returns {saturated, value}; the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX)
            return {1'b1, v};
        else
            return {1'b0, v + CNT_W'(1)};
    endfunction

    // Synchronizer stages followed by the history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            hist_p1 <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], ro_in};
            hist_p1 <= sync_p0[SYNC_STAGES-1];
        end
    end

    assign rise      = sync_p0[SYNC_STAGES-1] & ~hist_p1;
    assign last_gate = (gate_cnt == GATE_LAST);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start || cont) state_nxt = ARM;
            ARM:     state_nxt = COUNT;
            COUNT:   if (last_gate) state_nxt = DONE;
            DONE:    state_nxt = cont ? ARM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        inc      = sat_inc(edge_cnt);
        edge_nxt = edge_cnt;
        ovf_nxt  = win_ovf;
        if (state == COUNT && rise) begin
            edge_nxt = inc[CNT_W-1:0];
            ovf_nxt  = win_ovf | inc[CNT_W];
        end
    end

    // Window counters; the final COUNT cycle's edge is folded into the result
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt  <= '0;
            edge_cnt  <= '0;
            win_ovf   <= 1'b0;
            count_out <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                ARM: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    win_ovf  <= 1'b0;
                end
                COUNT: begin
                    if (!last_gate)
                        gate_cnt <= gate_cnt + GW'(1);
                    edge_cnt <= edge_nxt;
                    win_ovf  <= ovf_nxt;
                    if (last_gate) begin
                        count_out <= edge_nxt;
                        overflow  <= ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign count_valid = (state == DONE);

`ifdef RO_FREQ_BYTE_MUX_EN
    logic [15:0] count_lo16;

    assign count_lo16 = 16'(count_out);

    always_comb begin
        byte_out = 8'hA5;
        case (byte_sel)
            2'd0:    byte_out = count_lo16[7:0];
            2'd1:    byte_out = count_lo16[15:8];
            2'd2:    byte_out = {7'b0, overflow};
            default: byte_out = 8'hA5;
        endcase
    end
`endif

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter: a 100-cycle/16-bit instance and a 600-cycle/8-bit saturating instance.
module tb_ro_freq_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ro_in = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       busy;
    logic [15:0] count_out;
    logic       count_valid;
    logic       overflow;

    logic       s_start = 1'b0;
    logic       s_busy;
    logic [7:0] s_count;
    logic       s_valid;
    logic       s_ovf;

`ifdef RO_FREQ_BYTE_MUX_EN
    logic [1:0] byte_sel = 2'd0;
    logic [7:0] byte_out;
    logic [1:0] s_byte_sel = 2'd0;
    logic [7:0] s_byte_out;
`endif

    int total = 0;
    int bad = 0;
    int ro_period = 0;
    logic ro_level = 1'b0;
    int ph = 0;

    ro_freq_counter #(.GATE_CYCLES(100), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .cont(cont),
`ifdef RO_FREQ_BYTE_MUX_EN
        .byte_sel(byte_sel), .byte_out(byte_out),
`endif
        .busy(busy), .count_out(count_out), .count_valid(count_valid), .overflow(overflow)
    );

    ro_freq_counter #(.GATE_CYCLES(600), .CNT_W(8), .SYNC_STAGES(2)) sat (
        .clk(clk), .rst(rst), .ro_in(ro_in), .start(s_start), .cont(1'b0),
`ifdef RO_FREQ_BYTE_MUX_EN
        .byte_sel(s_byte_sel), .byte_out(s_byte_out),
`endif
        .busy(s_busy), .count_out(s_count), .count_valid(s_valid), .overflow(s_ovf)
    );

    always #5 clk = ~clk;

    // Oscillator model: constant level when ro_period==0, else square wave of ro_period cycles
    initial begin
        forever begin
            @(negedge clk);
            ph++;
            if (ro_period == 0)
                ro_in = ro_level;
            else
                ro_in = ((ph % ro_period) < (ro_period / 2));
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_s_start();
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
    endtask

    task automatic wait_main(input int bound, output int cyc, output bit ok);
        cyc = 0;
        ok = 1'b0;
        while (cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (count_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_sat(input int bound, output int cyc, output bit ok);
        cyc = 0;
        ok = 1'b0;
        while (cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (s_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (count_out !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count_out); end
        total++; if (count_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", count_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        total++; if (s_count !== 8'd0) begin bad++; $display("FAIL reset_s_count got=%0d want=0", s_count); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int cyc;
        bit ok;
        ro_period = 10;
        idle(20);
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_arm_busy got=%b want=1", busy); end
        wait_main(200, cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout got=none want=valid"); end
        // start sampled at edge t; DONE registered at edge t+101 (cycle t+2+GATE)
        total++; if (cyc !== 101) begin bad++; $display("FAIL single_latency got=%0d want=101", cyc); end
        total++; if (count_out !== 16'd10) begin bad++; $display("FAIL single_count got=%0d want=10", count_out); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL single_ovf got=%b want=0", overflow); end
        @(negedge clk);
        total++; if (count_valid !== 1'b0) begin bad++; $display("FAIL single_pulse_width got=%b want=0", count_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b want=0", busy); end
        total++; if (count_out !== 16'd10) begin bad++; $display("FAIL single_hold got=%0d want=10", count_out); end
    endtask

    task automatic test_const();
        int cyc;
        bit ok;
        ro_period = 0;
        ro_level = 1'b0;
        idle(10);
        pulse_start();
        wait_main(200, cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL low_timeout got=none want=valid"); end
        total++; if (count_out !== 16'd0) begin bad++; $display("FAIL low_count got=%0d want=0", count_out); end
        ro_level = 1'b1;
        idle(10);
        pulse_start();
        wait_main(200, cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL high_timeout got=none want=valid"); end
        total++; if (count_out !== 16'd0) begin bad++; $display("FAIL high_count got=%0d want=0", count_out); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL high_ovf got=%b want=0", overflow); end
    endtask

    task automatic test_saturate();
        int cyc;
        bit ok;
        ro_period = 2;
        idle(10);
        pulse_s_start();
        wait_sat(700, cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL sat_timeout got=none want=valid"); end
        total++; if (cyc !== 601) begin bad++; $display("FAIL sat_latency got=%0d want=601", cyc); end
        total++; if (s_count !== 8'd255) begin bad++; $display("FAIL sat_count got=%0d want=255", s_count); end
        total++; if (s_ovf !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b want=1", s_ovf); end
        ro_period = 10;
        idle(10);
        pulse_s_start();
        wait_sat(700, cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL unsat_timeout got=none want=valid"); end
        total++; if (s_count !== 8'd60) begin bad++; $display("FAIL unsat_count got=%0d want=60", s_count); end
        total++; if (s_ovf !== 1'b0) begin bad++; $display("FAIL unsat_ovf got=%b want=0", s_ovf); end
    endtask

    task automatic test_cont();
        int cyc;
        bit ok;
        bit seen;
        ro_period = 10;
        idle(5);
        cont = 1'b1;
        wait_main(300, cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL cont_first_timeout got=none want=valid"); end
        total++; if (count_out !== 16'd10) begin bad++; $display("FAIL cont_first_count got=%0d want=10", count_out); end
        for (int k = 0; k < 3; k++) begin
            wait_main(200, cyc, ok);
            total++; if (cyc !== 102) begin bad++; $display("FAIL cont_period[%0d] got=%0d want=102", k, cyc); end
            total++; if (count_out !== 16'd10) begin bad++; $display("FAIL cont_count[%0d] got=%0d want=10", k, count_out); end
        end
        idle(50);
        cont = 1'b0;
        wait_main(200, cyc, ok);
        total++; if (cyc !== 52) begin bad++; $display("FAIL cont_last_period got=%0d want=52", cyc); end
        total++; if (count_out !== 16'd10) begin bad++; $display("FAIL cont_last_count got=%0d want=10", count_out); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || count_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL cont_stop got=active want=idle"); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit ok;
        bit seen;
        ro_period = 10;
        pulse_start();
        idle(50);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (count_out !== 16'd0) begin bad++; $display("FAIL rstmid_count got=%0d want=0", count_out); end
        total++; if (count_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", count_valid); end
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (count_valid || busy) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_abandon got=active want=idle"); end
        pulse_start();
        wait_main(200, cyc, ok);
        total++; if (cyc !== 101) begin bad++; $display("FAIL rstmid_latency got=%0d want=101", cyc); end
        total++; if (count_out !== 16'd10) begin bad++; $display("FAIL rstmid_count_after got=%0d want=10", count_out); end
    endtask

`ifdef RO_FREQ_BYTE_MUX_EN
    task automatic test_byte_mux();
        logic [7:0] want [4];
        want[0] = 8'h0A;
        want[1] = 8'h00;
        want[2] = 8'h00;
        want[3] = 8'hA5;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            byte_sel = 2'(s);
            #1;
            total++; if (byte_out !== want[s]) begin bad++; $display("FAIL byte_sel%0d got=%h want=%h", s, byte_out, want[s]); end
        end
        s_byte_sel = 2'd1;
        #1;
        total++; if (s_byte_out !== 8'h00) begin bad++; $display("FAIL s_byte_hi got=%h want=00", s_byte_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_const();
        test_saturate();
        test_cont();
        test_reset_mid();
`ifdef RO_FREQ_BYTE_MUX_EN
        test_byte_mux();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
